// File: rtl/gfx256_write_combiner_if.sv
// rtl/gfx256_write_combiner_if.sv - Wishbone write-back bus between the combiner and the memory fabric
// Master side drives the cycle, slave side returns the acknowledge.
interface gfx256_write_combiner_if;
   logic         wbm_cyc_o;
   logic         wbm_stb_o;
   logic         wbm_we_o;
   logic [31:0]  wbm_adr_o;
   logic [31:0]  wbm_sel_o;
   logic [255:0] wbm_dat_o;
   logic         wbm_ack_i;

   modport master (
      output wbm_cyc_o,
      output wbm_stb_o,
      output wbm_we_o,
      output wbm_adr_o,
      output wbm_sel_o,
      output wbm_dat_o,
      input  wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o,
      input  wbm_stb_o,
      input  wbm_we_o,
      input  wbm_adr_o,
      input  wbm_sel_o,
      input  wbm_dat_o,
      output wbm_ack_i
   );
endinterface

// File: rtl/gfx256_write_combiner.sv
// rtl/gfx256_write_combiner.sv - merges byte-masked 256-bit renderer writes into one Wishbone write per 32-byte line
// One line buffer plus one pending slot for the write that evicted it.
module gfx256_write_combiner #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           write_i,
   input  logic [26:0]                    addr_i,
   input  logic [31:0]                    sel_i,
   input  logic [255:0]                   dat_i,
   output logic                           ack_o,
   input  logic                           flush_i,
   output logic                           idle_o,
   gfx256_write_combiner_if.master        wbm
);

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t       state;
   logic         valid;
   logic [26:0]  line_addr;
   logic [31:0]  line_sel;
   logic [255:0] line_dat;
   logic         pvalid;
   logic [26:0]  paddr;
   logic [31:0]  psel;
   logic [255:0] pdat;
   logic [7:0]   cnt;
   logic         ack_q;
   logic         cyc_q;

   logic [255:0] sel_mask;
   logic [255:0] merged_dat;
   logic         hit;

   always_comb begin
      sel_mask = '0;
      for (int b = 0; b < 32; b++) begin
         sel_mask[8*b +: 8] = {8{sel_i[b]}};
      end
      merged_dat = (line_dat & ~sel_mask) | (dat_i & sel_mask);
      hit        = valid && (addr_i == line_addr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         valid     <= 1'b0;
         line_addr <= '0;
         line_sel  <= '0;
         line_dat  <= '0;
         pvalid    <= 1'b0;
         paddr     <= '0;
         psel      <= '0;
         pdat      <= '0;
         cnt       <= '0;
         ack_q     <= 1'b0;
         cyc_q     <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (write_i) begin
                  cnt <= '0;
                  if (hit) begin
                     line_sel <= line_sel | sel_i;
                     line_dat <= merged_dat;
                     ack_q    <= 1'b1;
                     state    <= ST_ACK;
                  end else if (!valid || line_sel == '0) begin
                     // A held line with no enabled bytes has nothing to write back, so just replace it.
                     valid     <= 1'b1;
                     line_addr <= addr_i;
                     line_sel  <= sel_i;
                     line_dat  <= dat_i;
                     ack_q     <= 1'b1;
                     state     <= ST_ACK;
                  end else begin
                     pvalid <= 1'b1;
                     paddr  <= addr_i;
                     psel   <= sel_i;
                     pdat   <= dat_i;
                     cyc_q  <= 1'b1;
                     state  <= ST_BUS;
                  end
               end else if (valid) begin
                  if (flush_i || cnt == TIMEOUT_M1) begin
                     cnt <= '0;
                     if (line_sel != '0) begin
                        cyc_q <= 1'b1;
                        state <= ST_BUS;
                     end else begin
                        valid <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end

            ST_BUS: begin
               if (wbm.wbm_ack_i) begin
                  cyc_q <= 1'b0;
                  cnt   <= '0;
                  if (pvalid) begin
                     valid     <= 1'b1;
                     pvalid    <= 1'b0;
                     line_addr <= paddr;
                     line_sel  <= psel;
                     line_dat  <= pdat;
                     ack_q     <= 1'b1;
                     state     <= ST_ACK;
                  end else if (write_i) begin
                     // Write landing on the completing cycle goes straight into the freed line.
                     valid     <= 1'b1;
                     line_addr <= addr_i;
                     line_sel  <= sel_i;
                     line_dat  <= dat_i;
                     ack_q     <= 1'b1;
                     state     <= ST_ACK;
                  end else begin
                     valid <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else if (write_i && !pvalid) begin
                  pvalid <= 1'b1;
                  paddr  <= addr_i;
                  psel   <= sel_i;
                  pdat   <= dat_i;
               end
            end

            ST_ACK: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
               cyc_q <= 1'b0;
            end
         endcase
      end
   end

   assign ack_o         = ack_q;
   assign idle_o        = !valid && !pvalid && (state == ST_IDLE);
   assign wbm.wbm_cyc_o = cyc_q;
   assign wbm.wbm_stb_o = cyc_q;
   assign wbm.wbm_we_o  = cyc_q;
   assign wbm.wbm_adr_o = {line_addr, 5'b0};
   assign wbm.wbm_sel_o = line_sel;
   assign wbm.wbm_dat_o = line_dat;

endmodule

// File: tb/tb_gfx256_write_combiner.sv
// tb/tb_gfx256_write_combiner.sv - directed and randomized checks of the write combiner against a line model
// Wishbone slave responder with programmable ack delay records every write-back.
module tb_gfx256_write_combiner;

   localparam int TIMEOUT = 4;

   logic         clk_i   = 1'b0;
   logic         rst_i   = 1'b1;
   logic         write_i = 1'b0;
   logic         flush_i = 1'b0;
   logic [26:0]  addr_i  = '0;
   logic [31:0]  sel_i   = '0;
   logic [255:0] dat_i   = '0;
   logic         ack_o;
   logic         idle_o;

   gfx256_write_combiner_if wb ();

   gfx256_write_combiner #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .write_i (write_i),
      .addr_i  (addr_i),
      .sel_i   (sel_i),
      .dat_i   (dat_i),
      .ack_o   (ack_o),
      .flush_i (flush_i),
      .idle_o  (idle_o),
      .wbm     (wb.master)
   );

   always #5 clk_i = ~clk_i;

   int tick = 0;
   always @(posedge clk_i) tick <= tick + 1;

   typedef struct {
      logic [31:0]  adr;
      logic [31:0]  sel;
      logic         we;
      logic [255:0] dat;
   } txn_t;

   txn_t got_q[$];
   txn_t exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int ack_delay = 0;
   int wcnt = 0;
   int wback_tick = 0;
   int last_ack_tick = 0;

   // Reference line: what the renderer has written but the bus has not yet seen.
   logic         have = 1'b0;
   logic [26:0]  maddr = '0;
   logic [31:0]  msel = '0;
   logic [255:0] mdat = '0;

   always @(negedge clk_i) begin
      if (rst_i) begin
         wb.wbm_ack_i = 1'b0;
         wcnt = 0;
      end else if (wb.wbm_ack_i === 1'b1) begin
         wb.wbm_ack_i = 1'b0;
      end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
         if (wcnt >= ack_delay) begin
            wb.wbm_ack_i = 1'b1;
            wcnt = 0;
            wback_tick = tick;
            got_q.push_back('{wb.wbm_adr_o, wb.wbm_sel_o, wb.wbm_we_o, wb.wbm_dat_o});
         end else begin
            wcnt++;
         end
      end else begin
         wb.wbm_ack_i = 1'b0;
      end
   end

   function automatic logic [255:0] mask_dat(input logic [31:0] s, input logic [255:0] d);
      logic [255:0] r = '0;
      for (int b = 0; b < 32; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_flush();
      if (have && msel != '0) exp_q.push_back('{{maddr, 5'b0}, msel, 1'b1, mask_dat(msel, mdat)});
      have = 1'b0;
   endtask

   task automatic model_write(input logic [26:0] a, input logic [31:0] s, input logic [255:0] d);
      if (have && a == maddr) begin
         for (int b = 0; b < 32; b++) if (s[b]) mdat[8*b +: 8] = d[8*b +: 8];
         msel = msel | s;
      end else begin
         model_flush();
         have  = 1'b1;
         maddr = a;
         msel  = s;
         mdat  = d;
      end
   endtask

   task automatic wr(input logic [26:0] a, input logic [31:0] s, input logic [255:0] d, input int gap);
      int  t0;
      bit  goes_bus;
      repeat (gap) @(negedge clk_i);
      goes_bus = have && (a != maddr) && (msel != '0);
      write_i = 1'b1;
      addr_i  = a;
      sel_i   = s;
      dat_i   = d;
      t0      = tick;
      @(negedge clk_i);
      write_i = 1'b0;
      for (int i = 0; i < 100 && !ack_o; i++) @(negedge clk_i);
      check("ack_seen", ack_o, 1'b1);
      last_ack_tick = tick;
      if (goes_bus) check("miss_ack_lat", last_ack_tick - wback_tick, 1);
      else          check("ack_lat", last_ack_tick - t0, 1);
      model_write(a, s, d);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200 && !idle_o; i++) @(negedge clk_i);
      check(tag, idle_o, 1'b1);
   endtask

   task automatic do_flush(input int gap);
      repeat (gap) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      wait_idle("flush_idle");
      model_flush();
   endtask

   task automatic compare_txns(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_adr"}, got_q[i].adr, exp_q[i].adr);
         check({tag, "_sel"}, got_q[i].sel, exp_q[i].sel);
         check({tag, "_we"},  got_q[i].we,  1'b1);
         check({tag, "_dat"}, mask_dat(got_q[i].sel, got_q[i].dat), exp_q[i].dat);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int k;
      logic [255:0] d;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_ack", ack_o, 1'b0);
      check("rst_idle", idle_o, 1'b1);
      check("rst_cyc", wb.wbm_cyc_o, 1'b0);
      check("rst_stb", wb.wbm_stb_o, 1'b0);
      check("rst_we", wb.wbm_we_o, 1'b0);
      check("rst_adr", wb.wbm_adr_o, 32'h0);
      check("rst_sel", wb.wbm_sel_o, 32'h0);
      check("rst_dat", wb.wbm_dat_o, 256'h0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Empty merge
      wr(27'h100, 32'h0000000F, 256'hAAAAAAAA, 1);
      wr(27'h100, 32'h000000F0, 256'hBBBBBBBB << 32, 1);
      do_flush(1);
      check("merge_count", got_q.size(), 1);
      check("merge_adr", got_q[0].adr, 32'h00002000);
      check("merge_sel", got_q[0].sel, 32'h000000FF);
      d = got_q[0].dat;
      check("merge_dat", d[63:0], 64'hBBBBBBBB_AAAAAAAA);
      compare_txns("merge");

      // Overlap: later byte wins
      wr(27'h200, 32'h1, 256'h11, 1);
      wr(27'h200, 32'h1, 256'h22, 2);
      do_flush(1);
      check("ovl_sel", got_q[0].sel, 32'h1);
      d = got_q[0].dat;
      check("ovl_byte0", d[7:0], 8'h22);
      compare_txns("ovl");

      // Miss with slow bus ack
      wr(27'h100, 32'h3, 256'h5A5A, 1);
      ack_delay = 3;
      wr(27'h101, 32'h4, 256'h77 << 16, 1);
      check("miss_adr", got_q[0].adr, 32'h00002000);
      check("miss_idle", idle_o, 1'b0);
      ack_delay = 0;
      do_flush(1);
      check("miss_held_adr", got_q[1].adr, 32'h00002020);
      compare_txns("miss");

      // Timeout
      wr(27'h300, 32'h0F00_0000, {8{32'hC0DE_F00D}}, 1);
      k = tick;
      for (int i = 0; i < 50 && !wb.wbm_cyc_o; i++) @(negedge clk_i);
      check("timeout_lat", tick - k, TIMEOUT + 1);
      wait_idle("timeout_idle");
      model_flush();
      compare_txns("timeout");

      // Collision: write on the expiring cycle merges and restarts the counter
      wr(27'h400, 32'h1, 256'h01, 1);
      wr(27'h400, 32'h2, 256'h0200, TIMEOUT);
      check("coll_no_cyc", wb.wbm_cyc_o, 1'b0);
      check("coll_no_txn", got_q.size(), 0);
      k = tick;
      for (int i = 0; i < 50 && !wb.wbm_cyc_o; i++) @(negedge clk_i);
      check("coll_restart", tick - k, TIMEOUT + 1);
      wait_idle("coll_idle");
      model_flush();
      check("coll_sel", got_q[0].sel, 32'h3);
      compare_txns("coll");

      // Reset while the bus cycle is outstanding
      ack_delay = 1000;
      wr(27'h500, 32'hFF, {8{32'h1234_5678}}, 1);
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("rbus_cyc_up", wb.wbm_cyc_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rbus_cyc", wb.wbm_cyc_o, 1'b0);
      check("rbus_idle", idle_o, 1'b1);
      rst_i = 1'b0;
      ack_delay = 0;
      have = 1'b0;
      repeat (20) @(negedge clk_i);
      check("rbus_no_cyc", wb.wbm_cyc_o, 1'b0);
      compare_txns("rbus");

      // Randomized traffic over a few neighbouring lines
      for (int n = 0; n < 60; n++) begin
         ack_delay = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) begin
            do_flush($urandom_range(1, TIMEOUT));
         end else begin
            wr(27'h100 + 27'($urandom_range(0, 2)), $urandom(), {8{$urandom()}},
               $urandom_range(1, TIMEOUT));
         end
      end
      do_flush(1);
      compare_txns("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gfx256_write_combiner.md
Name: gfx256_write_combiner

Overview:
- Sits directly downstream of the 256-bit pixel renderer, between the renderer's memory-write outputs and the Wishbone master port.
- Holds one 256-bit line buffer and merges successive byte-masked pixel or z writes that hit the same 32-byte line.
- Issues one Wishbone write per line, which cuts bus traffic for horizontal spans and for 8/16-bit pixels.
- Acknowledges each incoming write with the single-cycle ack the renderer expects.

Parameters:
- TIMEOUT, 16: idle cycles a valid, unmodified line is held before it is flushed automatically. Range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset: synchronous, active-high
- write_i  in  1  write request pulse from renderer
- addr_i  in  27 [31:5]  line address of the write
- sel_i  in  32  byte enables
- dat_i  in  256  write data
- ack_o  out  1  one-cycle acknowledge of an accepted write
- flush_i  in  1  request to write back the held line (end of command)
- idle_o  out  1  high when no line is held and no bus cycle is active
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  byte address, {line_addr,5'b0}
- wbm_sel_o  out  32  byte selects
- wbm_dat_o  out  256  write data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Internal state:
  - line: valid, line_addr[31:5], line_sel[31:0], line_dat[255:0].
  - pending: pvalid, paddr, psel, pdat.
  - Idle counter: 8 bits.
  - FSM: ST_IDLE, ST_BUS, ST_ACK.
- Reset values:
  - All outputs 0 except idle_o = 1.
  - valid, pvalid and the counter are 0; state is ST_IDLE.
  - Reset during ST_BUS drops cyc/stb on the next edge and discards both the line and pending data.
- Protocol:
  - The renderer issues a single-cycle write_i, then waits for ack_o before issuing another.
  - A write_i while pvalid = 1 or while ack_o is pending is a protocol violation and is ignored.
- ST_IDLE, when write_i = 1:
  - Hit (valid and addr_i == line_addr): for each byte b with sel_i[b] set, line_dat byte b takes dat_i byte b; line_sel |= sel_i; counter cleared. Go to ST_ACK.
  - Empty (!valid): load the line from the inputs; valid = 1; counter cleared. Go to ST_ACK.
  - Miss (valid and addr differs): capture the inputs into pending, pvalid = 1. Go to ST_BUS.
- ST_IDLE, otherwise, while valid:
  - The counter increments each cycle.
  - When counter == TIMEOUT-1, or when flush_i = 1, go to ST_BUS.
  - A write_i in the same cycle as a timeout or flush_i takes priority and the flush does not happen.
  - flush_i while !valid is ignored.
- ST_BUS:
  - cyc = stb = we = 1; wbm_adr/sel/dat are driven from the line registers and held stable.
  - On wbm_ack_i: deassert cyc/stb/we on the next edge.
    - If pvalid: line = pending, valid = 1, pvalid = 0, counter cleared, go to ST_ACK.
    - Else: valid = 0, go to ST_IDLE.
  - A write_i arriving in ST_BUS during a timeout or flush cycle is captured into pending (pvalid = 1) and handled exactly as a miss.
- ST_ACK: ack_o = 1 for exactly one cycle, then go to ST_IDLE.
- Latency:
  - Hit or empty: ack_o is asserted 1 cycle after write_i.
  - Miss: ack_o is asserted 1 cycle after the wbm_ack_i that completes the flush.
- idle_o = !valid && !pvalid && state == ST_IDLE.
- Wishbone write-back is never issued with line_sel == 0.

Test Plan:
- Empty merge: write 0x100 sel 0x0000000F data byte0..3 = AA; then 0x100 sel 0x000000F0 BB; then flush_i.
  - ack_o is asserted 1 cycle after each write.
  - Exactly one bus write: adr 0x00002000, sel 0x000000FF, bytes 0-3 = AA, 4-7 = BB.
- Overlap: two writes to the same line, both sel 0x1, data 11 then 22.
  - The single flushed write has byte0 = 22 and sel 0x1.
- Miss: line 0x100 held, write to 0x101, wbm_ack_i delayed 3 cycles.
  - Bus write to 0x2000 completes.
  - ack_o is asserted 1 cycle after wbm_ack_i.
  - The held line is now 0x101; idle_o = 0.
- Timeout with TIMEOUT = 4: write, then no activity.
  - cyc rises 4 cycles after ack_o.
  - idle_o = 1 after the bus write completes.
- Collision: write_i in the same cycle the counter expires.
  - The write merges, no bus cycle starts, and the counter restarts.
- Reset during ST_BUS: cyc = 0 on the next edge; idle_o = 1; no later write of the discarded line.
